// File: rtl/sphere_cart_seq.sv
// Spherical-to-Cartesian sequencer. It shares one external fixed-latency signed multiplier
// between four products: rc = r*cos_el, z = r*sin_el, x = rc*cos_az, y = rc*sin_az.
// Products are picked up by cycle count alone because the multiplier returns no valid flag.
module sphere_cart_seq #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] radius,
  input  logic [15:0] sin_el,
  input  logic [15:0] cos_el,
  input  logic [15:0] sin_az,
  input  logic [15:0] cos_az,
  output logic        mul_en,
  output logic [16:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [32:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] x,
  output logic [16:0] y,
  output logic [16:0] z,
  output logic        rdy
);

  typedef enum logic [2:0] {StIdle, StIssEl, StWaitEl, StIssAz, StWaitAz, StOut} state_e;

  // Cycle offsets from the accept cycle (cycle 0).
  localparam logic [4:0] CntRc  = 5'(MUL_LAT + 1);
  localparam logic [4:0] CntZ   = 5'(MUL_LAT + 2);
  localparam logic [4:0] CntAz1 = 5'(MUL_LAT + 3);
  localparam logic [4:0] CntX   = 5'(2 * MUL_LAT + 2);
  localparam logic [4:0] CntY   = 5'(2 * MUL_LAT + 3);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] r_q, sin_el_q, cos_el_q, sin_az_q, cos_az_q;
  logic [16:0] rc_q, z_q, x_q;
  logic [16:0] prod;
  logic        accept, busy;
  logic        unused_p;

  // Q1.15 rescale: arithmetic >>> 15 then keep 17 bits, i.e. bits [31:15].
  assign prod     = mul_p[31:15];
  assign unused_p = ^{mul_p[32], mul_p[14:0]};

  assign busy      = (state_q != StIdle) && (state_q != StOut);
  assign in_ready  = rst && en && (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign out_valid = rst && (state_q == StOut);
  assign rdy       = !rst || (state_q == StIdle);

  // Next state and the cycle counter; a started conversion always runs to OUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = 5'd1;
    end else if (busy) begin
      cnt_d = cnt_q + 5'd1;
    end
    unique case (state_q)
      StIdle:   if (accept) state_d = StIssEl;
      // With MUL_LAT = 1 rc is already captured in the second issue cycle.
      StIssEl:  if (cnt_q == 5'd2) state_d = (cnt_q == CntRc) ? StIssAz : StWaitEl;
      StWaitEl: if (cnt_q == CntRc) state_d = StIssAz;
      StIssAz:  if (cnt_q == CntAz1) state_d = StWaitAz;
      StWaitAz: if (cnt_q == CntY) state_d = StOut;
      StOut:    if (out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Operand mux: operands are forced to zero whenever no strobe is issued.
  always_comb begin
    mul_en = 1'b0;
    mul_a  = '0;
    mul_b  = '0;
    if (rst && state_q == StIssEl) begin
      mul_en = 1'b1;
      mul_a  = {1'b0, r_q};
      mul_b  = (cnt_q == 5'd1) ? cos_el_q : sin_el_q;
    end else if (rst && state_q == StIssAz) begin
      mul_en = 1'b1;
      mul_a  = rc_q;
      mul_b  = (cnt_q == CntZ) ? cos_az_q : sin_az_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sample latch and product capture; visible x/y/z change only when entering OUT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q      <= '0;
      sin_el_q <= '0;
      cos_el_q <= '0;
      sin_az_q <= '0;
      cos_az_q <= '0;
      rc_q     <= '0;
      z_q      <= '0;
      x_q      <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
    end else begin
      if (accept) begin
        r_q      <= radius;
        sin_el_q <= sin_el;
        cos_el_q <= cos_el;
        sin_az_q <= sin_az;
        cos_az_q <= cos_az;
      end
      if (busy) begin
        if (cnt_q == CntRc) rc_q <= prod;
        if (cnt_q == CntZ)  z_q  <= prod;
        if (cnt_q == CntX)  x_q  <= prod;
        if (cnt_q == CntY) begin
          x <= x_q;
          y <= prod;
          z <= z_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_sphere_cart_seq.sv
// Bench for sphere_cart_seq: external multiplier pipeline, a per-cycle reference model
// built from the conversion timeline, and directed samples with literal expected results.
module tb_sphere_cart_seq;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_ready, out_ready, out_valid, rdy, mul_en;
  logic [15:0] radius, sin_el, cos_el, sin_az, cos_az, mul_b;
  logic [16:0] mul_a, x, y, z;
  logic [32:0] mul_p;

  int nvec = 0, nfail = 0, cyc = 0, acc_cyc = 0, mul_cnt = 0;

  sphere_cart_seq #(.MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .radius(radius), .sin_el(sin_el), .cos_el(cos_el), .sin_az(sin_az), .cos_az(cos_az),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y), .z(z), .rdy(rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mul_en) mul_cnt <= mul_cnt + 1;

  // Fixed-latency signed multiplier.
  logic [32:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= 33'($signed(mul_a)) * 33'($signed(mul_b));
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[L-1];

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint scl(input longint a, input longint b);
    return (a * b) >>> 15;
  endfunction

  // Reference model: conversion timeline relative to the accept cycle.
  bit     m_busy = 0;
  int     m_acc = 0;
  longint m_r, m_ce, m_se, m_ca, m_sa, m_rc, p_x, p_y, p_z;
  longint m_x = 0, m_y = 0, m_z = 0;

  always @(negedge clk) begin
    int rel;
    bit em, eo, hs, ac;
    longint ea, eb;
    if (!rst) begin
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_mul_en", longint'(mul_en), 0);
      chk("rst_rdy", longint'(rdy), 1);
      m_busy = 0;
      m_x = 0; m_y = 0; m_z = 0;
    end else begin
      rel = cyc - m_acc;
      em = m_busy && (rel == 1 || rel == 2 || rel == L + 2 || rel == L + 3);
      ea = 0; eb = 0;
      if (m_busy && rel == 1)     begin ea = m_r;  eb = m_ce; end
      if (m_busy && rel == 2)     begin ea = m_r;  eb = m_se; end
      if (m_busy && rel == L + 2) begin ea = m_rc; eb = m_ca; end
      if (m_busy && rel == L + 3) begin ea = m_rc; eb = m_sa; end
      if (m_busy && rel == 4 + 2 * L) begin m_x = p_x; m_y = p_y; m_z = p_z; end
      eo = m_busy && rel >= 4 + 2 * L;
      chk("in_ready", longint'(in_ready), longint'(!m_busy && en));
      chk("rdy", longint'(rdy), longint'(!m_busy));
      chk("out_valid", longint'(out_valid), longint'(eo));
      chk("mul_en", longint'(mul_en), longint'(em));
      chk("mul_a", longint'($signed(mul_a)), ea);
      chk("mul_b", longint'($signed(mul_b)), eb);
      chk("x", longint'($signed(x)), m_x);
      chk("y", longint'($signed(y)), m_y);
      chk("z", longint'($signed(z)), m_z);
      hs = m_busy && eo && out_ready;
      ac = !m_busy && en && in_valid;
      if (hs) m_busy = 0;
      if (ac) begin
        m_busy = 1;
        m_acc  = cyc;
        m_r  = longint'(radius);
        m_ce = longint'($signed(cos_el));
        m_se = longint'($signed(sin_el));
        m_ca = longint'($signed(cos_az));
        m_sa = longint'($signed(sin_az));
        m_rc = scl(m_r, m_ce);
        p_z  = scl(m_r, m_se);
        p_x  = scl(m_rc, m_ca);
        p_y  = scl(m_rc, m_sa);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic [15:0] r, ce, se, ca, sa);
    radius = r; cos_el = ce; sin_el = se; cos_az = ca; sin_az = sa;
    in_valid = 1'b1;
  endtask

  // Waits for the handshake, then scrambles the inputs to prove they were latched.
  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = in_valid && in_ready;
    end
    chk("accept_seen", longint'(got), 1);
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
    radius = 16'($urandom); cos_el = 16'($urandom); sin_el = 16'($urandom);
    cos_az = 16'($urandom); sin_az = 16'($urandom);
  endtask

  task automatic wait_out(output int lat);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("out_seen", longint'(got), 1);
    lat = cyc - acc_cyc;
  endtask

  task automatic chk_xyz(input string nm, input longint ex, ey, ez);
    chk({nm, "_x"}, longint'($signed(x)), ex);
    chk({nm, "_y"}, longint'($signed(y)), ey);
    chk({nm, "_z"}, longint'($signed(z)), ez);
  endtask

  initial begin
    int lat, mc, h;
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    radius = '0; sin_el = '0; cos_el = '0; sin_az = '0; cos_az = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_in_ready", longint'(in_ready), 1);
    chk_xyz("post_rst", 0, 0, 0);

    // rc = 999, so y = floor(999*32767/32768) = 998.
    tick();
    mc = mul_cnt;
    drive_sample(16'd1000, 16'd32767, 16'd0, 16'd0, 16'd32767);
    wait_accept();
    wait_out(lat);
    chk("t1_latency", lat, 10);
    chk_xyz("t1", 0, 998, 0);
    chk("t1_mul_pulses", mul_cnt - mc, 4);

    // Full-scale: rc = -65535, x = +65535 without overflow.
    tick();
    drive_sample(16'd65535, 16'h8000, 16'd0, 16'h8000, 16'd0);
    wait_accept();
    wait_out(lat);
    chk_xyz("t2", 65535, 0, 0);

    // Truncation toward minus infinity: z = floor(-3/32768) = -1.
    tick();
    drive_sample(16'd3, 16'd32767, 16'hFFFF, 16'd32767, 16'h8000);
    wait_accept();
    wait_out(lat);
    chk_xyz("t3", 1, -2, -1);

    // Output back-pressure for 20 cycles with the next sample already offered.
    tick();
    out_ready = 1'b0;
    drive_sample(16'd20000, 16'd16384, 16'hC000, 16'hC000, 16'd8192);
    wait_accept();
    wait_out(lat);
    chk("t4_latency", lat, 10);
    chk_xyz("t4", -5000, 2500, -10000);
    tick();
    drive_sample(16'd3, 16'd32767, 16'hFFFF, 16'd32767, 16'h8000);
    repeat (20) tick();
    chk("t4_hold_valid", longint'(out_valid), 1);
    chk("t4_hold_in_ready", longint'(in_ready), 0);
    chk_xyz("t4_hold", -5000, 2500, -10000);
    out_ready = 1'b1;
    @(negedge clk);
    h = cyc;
    wait_accept();
    chk("t4_accept_gap", acc_cyc - h, 1);
    wait_out(lat);
    chk_xyz("t4b", 1, -2, -1);

    // Reset in cycle 4 of a conversion, then a fresh sample.
    tick();
    drive_sample(16'd65535, 16'h8000, 16'd0, 16'h8000, 16'd0);
    wait_accept();
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk_xyz("t5_cleared", 0, 0, 0);
    tick();
    drive_sample(16'd1000, 16'd32767, 16'd0, 16'd0, 16'd32767);
    wait_accept();
    wait_out(lat);
    chk("t5_latency", lat, 10);
    chk_xyz("t5", 0, 998, 0);

    // en = 0 blocks accepts; dropping en mid-flight lets the conversion finish.
    tick();
    en = 1'b0;
    drive_sample(16'd20000, 16'd16384, 16'hC000, 16'hC000, 16'd8192);
    mc = mul_cnt;
    repeat (8) tick();
    @(negedge clk);
    chk("t6_blocked_pulses", mul_cnt - mc, 0);
    chk("t6_blocked_rdy", longint'(rdy), 1);
    tick();
    en = 1'b1;
    wait_accept();
    tick();
    en = 1'b0;
    wait_out(lat);
    chk_xyz("t6", -5000, 2500, -10000);
    tick();
    @(negedge clk);
    chk("t6_idle_rdy", longint'(rdy), 1);
    chk("t6_idle_in_ready", longint'(in_ready), 0);
    en = 1'b1;

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
